control_sequencer: RTL and testbench

- Multi-cycle instruction sequencer directly upstream of the processor/ALU datapath.
- Accepts 8-bit instruction bytes over a valid/ready handshake and decodes them.
- Drives the ALU function select, register read/write addresses and the write-enable pulse for the 4-entry register file.
- Supports two-byte immediate loads, a HALT/resume state and a sticky illegal-opcode flag.

---
 rtl/control_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer feeding the ALU datapath and 4-entry register file.
// Define SEQ_INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module control_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter logic [3:0]  ALU_LAST    = 4'h9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        go,
    output logic [3:0]  alu_sel,
    output logic [1:0]  rd_addr_a,
    output logic [1:0]  rd_addr_b,
    output logic [1:0]  wr_addr,
    output logic        wr_en,
    output logic [1:0]  wr_src,
    output logic [7:0]  imm,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_IMM,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_IMM = 2'd1;
    localparam logic [1:0] SRC_RDB = 2'd2;

    localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  op_q;
    logic [1:0]  cnt_q;
    logic        instr_ready_q;
    logic [3:0]  alu_sel_q;
    logic [1:0]  rd_addr_a_q;
    logic [1:0]  rd_addr_b_q;
    logic [1:0]  wr_addr_q;
    logic        wr_en_q;
    logic [1:0]  wr_src_q;
    logic [7:0]  imm_q;
    logic        busy_q;
    logic        halted_q;
    logic        illegal_q;
    logic        is_alu;

    assign is_alu = (op_q != OP_NOP) && (op_q <= ALU_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_FETCH;
            op_q          <= 4'h0;
            cnt_q         <= 2'd0;
            instr_ready_q <= 1'b0;
            alu_sel_q     <= 4'h0;
            rd_addr_a_q   <= 2'd0;
            rd_addr_b_q   <= 2'd0;
            wr_addr_q     <= 2'd0;
            wr_en_q       <= 1'b0;
            wr_src_q      <= SRC_ALU;
            imm_q         <= 8'h00;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // Ready rises on the first clock here, covering the post-reset entry.
                    instr_ready_q <= 1'b1;
                    if (instr_valid && instr_ready_q) begin
                        op_q          <= instr[7:4];
                        rd_addr_a_q   <= instr[3:2];
                        rd_addr_b_q   <= instr[1:0];
                        wr_addr_q     <= instr[3:2];
                        instr_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op_q == OP_NOP) begin
                        busy_q        <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= S_FETCH;
                    end else if (is_alu) begin
                        alu_sel_q <= op_q;
                        wr_src_q  <= SRC_ALU;
                        cnt_q     <= 2'd0;
                        state_q   <= S_EXEC;
                    end else if (op_q == OP_LDI) begin
                        instr_ready_q <= 1'b1;
                        state_q       <= S_IMM;
                    end else if (op_q == OP_MOV) begin
                        wr_src_q <= SRC_RDB;
                        wr_en_q  <= 1'b1;
                        state_q  <= S_WB;
                    end else if (op_q == OP_HALT) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        illegal_q     <= 1'b1;
                        busy_q        <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= S_FETCH;
                    end
                end
                S_IMM: begin
                    if (instr_valid && instr_ready_q) begin
                        imm_q         <= instr;
                        wr_src_q      <= SRC_IMM;
                        instr_ready_q <= 1'b0;
                        wr_en_q       <= 1'b1;
                        state_q       <= S_WB;
                    end
                end
                S_EXEC: begin
                    // The strobe is raised on the WB entry edge so it lines up with the WB cycle.
                    if (cnt_q == EXEC_LAST) begin
                        wr_en_q <= 1'b1;
                        state_q <= S_WB;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_WB: begin
                    busy_q        <= 1'b0;
                    instr_ready_q <= 1'b1;
                    state_q       <= S_FETCH;
                end
                S_HALT: begin
                    if (go) begin
                        halted_q      <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_sel     = alu_sel_q;
    assign rd_addr_a   = rd_addr_a_q;
    assign rd_addr_b   = rd_addr_b_q;
    assign wr_addr     = wr_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_src      = wr_src_q;
    assign imm         = imm_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;

`ifdef SEQ_INSTR_COUNT_EN
    logic        retire;
    logic [15:0] count_q;
    logic [15:0] count_d;

    // Retires on WB exit and on every DECODE exit that does not continue the instruction.
    always_comb begin
        retire  = (state_q == S_WB) ||
                  ((state_q == S_DECODE) && !is_alu && (op_q != OP_LDI) && (op_q != OP_MOV));
        count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'h0000;
        end else if (retire) begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a latency/effect model of the ISA.
module tb_control_sequencer;

    localparam int E = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  instr = 8'h00;
    logic        instr_valid = 1'b0;
    logic        go = 1'b0;
    logic        instr_ready;
    logic [3:0]  alu_sel;
    logic [1:0]  rd_addr_a, rd_addr_b, wr_addr, wr_src;
    logic        wr_en, busy, halted, illegal;
    logic [7:0]  imm;
    logic [15:0] instr_count;

    control_sequencer #(.EXEC_CYCLES(E), .ALU_LAST(4'h9)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .go(go), .alu_sel(alu_sel),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
        .wr_en(wr_en), .wr_src(wr_src), .imm(imm), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_illegal;
    logic [15:0] m_count;

    // Observations of one instruction, relative to the accept edge (k=1 is the cycle after it)
    bit          o_ok;
    int          o_wait, o_nwr, o_wrk, o_endk;
    logic [1:0]  o_addr, o_src, o_rda, o_rdb;
    logic [3:0]  o_alu;
    logic [7:0]  o_imm;
    logic        o_busy1;

    function automatic bit is_alu_op(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h9);
    endfunction

    function automatic int exp_wr_k(input logic [3:0] op);
        if (is_alu_op(op)) return 2 + E;
        if (op == 4'hB) return 2;
        return -1;
    endfunction

    function automatic int exp_end_k(input logic [3:0] op);
        if (is_alu_op(op)) return 3 + E;
        if (op == 4'hB) return 3;
        return 2;
    endfunction

    function automatic logic [1:0] exp_src(input logic [3:0] op);
        if (op == 4'hB) return 2'd2;
        if (op == 4'hA) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [15:0] exp_count();
`ifdef SEQ_INSTR_COUNT_EN
        return m_count;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b);
        o_ok = 1'b0;
        o_wait = 0;
        go = 1'b0;
        instr = b;
        instr_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (instr_ready === 1'b1) begin
                @(posedge clk);
                o_ok = 1'b1;
                break;
            end
            @(negedge clk);
            o_wait++;
        end
        if (o_ok) @(negedge clk);
        instr_valid = 1'b0;
        instr = 8'($urandom);
    endtask

    task automatic observe();
        o_nwr = 0;
        o_wrk = -1;
        o_endk = -1;
        o_busy1 = busy;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge clk);
            if (wr_en === 1'b1) begin
                o_nwr++;
                o_wrk = k;
                o_addr = wr_addr;
                o_src = wr_src;
                o_alu = alu_sel;
                o_imm = imm;
                o_rda = rd_addr_a;
                o_rdb = rd_addr_b;
            end
            if (instr_ready === 1'b1 || halted === 1'b1) begin
                o_endk = k;
                break;
            end
            go = 1'($urandom_range(0, 1));
        end
        go = 1'b0;
    endtask

    task automatic issue(input logic [7:0] b);
        send_byte(b);
        if (o_ok) observe();
        else o_endk = -1;
    endtask

    task automatic wake(input int n, output int bad, output bit woke);
        instr = 8'h11;
        instr_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (instr_ready !== 1'b0 || halted !== 1'b1) bad++;
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        woke = (halted === 1'b0) && (instr_ready === 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        instr_valid = 1'b0;
        go = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_illegal = 1'b0;
        m_count = 16'h0000;
    endtask

    task automatic test_reset();
        logic [40:0] zv;
        int nw;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        zv = {instr_ready, alu_sel, rd_addr_a, rd_addr_b, wr_addr, wr_en, wr_src,
              imm, busy, halted, illegal, instr_count};
        checks++;
        if (zv !== 41'h0) begin errors++; $display("FAIL reset_outputs: got %0h expected 0", zv); end
        rst = 1'b1;
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_clk: got %0b expected 0", instr_ready); end
        @(negedge clk);
        checks++;
        if ({instr_ready, busy, halted} !== 3'b100) begin
            errors++; $display("FAIL reset_ready_after_clk: got %b expected 100", {instr_ready, busy, halted});
        end
        m_illegal = 1'b0;
        m_count = 16'h0000;
        issue(8'hC0);
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL reset_pre_illegal: got %0b expected 1", illegal); end
        send_byte(8'h37);
        @(negedge clk);
        rst = 1'b0;
        #1;
        zv = {instr_ready, alu_sel, rd_addr_a, rd_addr_b, wr_addr, wr_en, wr_src,
              imm, busy, halted, illegal, instr_count};
        checks++;
        if (zv !== 41'h0) begin errors++; $display("FAIL reset_async_mid_exec: got %0h expected 0", zv); end
        nw = 0;
        @(negedge clk);
        if (wr_en !== 1'b0) nw++;
        rst = 1'b1;
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset2_ready_before_clk: got %0b expected 0", instr_ready); end
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset2_ready_after_clk: got %0b expected 1", instr_ready); end
        for (int i = 0; i < 5; i++) begin
            if (wr_en !== 1'b0 || busy !== 1'b0) nw++;
            @(negedge clk);
        end
        checks++;
        if (nw !== 0) begin errors++; $display("FAIL reset_abandon: got %0d stray cycles expected 0", nw); end
        m_illegal = 1'b0;
        m_count = 16'h0000;
    endtask

    task automatic test_alu();
        issue(8'h36);
        m_count++;
        checks++;
        if (o_nwr !== 1 || o_wrk !== 2 + E) begin
            errors++; $display("FAIL alu_wr_timing: got n=%0d k=%0d expected n=1 k=%0d", o_nwr, o_wrk, 2 + E);
        end
        checks++;
        if ({o_alu, o_rda, o_rdb, o_addr, o_src} !== {4'h3, 2'd1, 2'd2, 2'd1, 2'd0}) begin
            errors++; $display("FAIL alu_fields: got %0h expected %0h",
                {o_alu, o_rda, o_rdb, o_addr, o_src}, {4'h3, 2'd1, 2'd2, 2'd1, 2'd0});
        end
        checks++;
        if (o_endk !== 3 + E || o_busy1 !== 1'b1) begin
            errors++; $display("FAIL alu_ready_again: got k=%0d busy=%0b expected k=%0d busy=1", o_endk, o_busy1, 3 + E);
        end
    endtask

    task automatic test_ldi();
        int bad;
        issue(8'hA8);
        checks++;
        if (o_endk !== 2 || o_nwr !== 0) begin
            errors++; $display("FAIL ldi_imm_entry: got k=%0d n=%0d expected k=2 n=0", o_endk, o_nwr);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (instr_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL ldi_ready_hold: got %0d low cycles expected 0", bad); end
        send_byte(8'h5C);
        checks++;
        if (o_ok !== 1'b1 || o_wait !== 0) begin
            errors++; $display("FAIL ldi_second_accept: got ok=%0b wait=%0d expected ok=1 wait=0", o_ok, o_wait);
        end
        observe();
        m_count++;
        checks++;
        if (o_nwr !== 1 || o_wrk !== 1) begin
            errors++; $display("FAIL ldi_wr_timing: got n=%0d k=%0d expected n=1 k=1", o_nwr, o_wrk);
        end
        checks++;
        if ({o_imm, o_addr, o_src} !== {8'h5C, 2'd2, 2'd1}) begin
            errors++; $display("FAIL ldi_fields: got %0h expected %0h", {o_imm, o_addr, o_src}, {8'h5C, 2'd2, 2'd1});
        end
    endtask

    task automatic test_illegal();
        issue(8'hC0);
        m_illegal = 1'b1;
        m_count++;
        checks++;
        if (illegal !== 1'b1 || o_nwr !== 0 || o_endk !== 2) begin
            errors++; $display("FAIL illegal_set: got ill=%0b n=%0d k=%0d expected 1 0 2", illegal, o_nwr, o_endk);
        end
        issue(8'h00);
        m_count++;
        checks++;
        if (illegal !== 1'b1 || o_nwr !== 0) begin
            errors++; $display("FAIL illegal_sticky: got ill=%0b n=%0d expected 1 0", illegal, o_nwr);
        end
        checks++;
        if (instr_count !== exp_count()) begin
            errors++; $display("FAIL illegal_count: got %0d expected %0d", instr_count, exp_count());
        end
    endtask

    task automatic test_halt();
        int bad;
        bit woke;
        issue(8'hF0);
        m_count++;
        checks++;
        if (halted !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL halt_enter: got h=%0b r=%0b b=%0b expected 1 0 0", halted, instr_ready, busy);
        end
        wake(3, bad, woke);
        checks++;
        if (bad !== 0 || woke !== 1'b1) begin
            errors++; $display("FAIL halt_wake: got bad=%0d woke=%0b expected 0 1", bad, woke);
        end
        send_byte(8'h11);
        checks++;
        if (o_ok !== 1'b1 || o_wait !== 0) begin
            errors++; $display("FAIL halt_pending_accept: got ok=%0b wait=%0d expected 1 0", o_ok, o_wait);
        end
        observe();
        m_count++;
        checks++;
        if (o_wrk !== 2 + E || o_alu !== 4'h1 || o_addr !== 2'd0) begin
            errors++; $display("FAIL halt_next_instr: got k=%0d alu=%0h a=%0d expected %0d 1 0", o_wrk, o_alu, o_addr, 2 + E);
        end
    endtask

    task automatic test_count();
        int bad;
        bit woke;
        logic [15:0] want;
        apply_reset();
        issue(8'h00);
        issue(8'hA4);
        send_byte(8'h99);
        observe();
        issue(8'h16);
        issue(8'hF0);
`ifdef SEQ_INSTR_COUNT_EN
        want = 16'd4;
`else
        want = 16'd0;
`endif
        checks++;
        if (instr_count !== want) begin
            errors++; $display("FAIL count_sequence: got %0d expected %0d", instr_count, want);
        end
        wake(1, bad, woke);
        checks++;
        if (woke !== 1'b1) begin errors++; $display("FAIL count_wake: got %0b expected 1", woke); end
        m_count = 16'd4;
        m_illegal = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] b, ib;
        logic [3:0] op;
        int gap, bad;
        bit woke, wrs;
        for (int n = 0; n < 80; n++) begin
            b = 8'($urandom_range(0, 255));
            op = b[7:4];
            issue(b);
            checks++;
            if (o_ok !== 1'b1 || o_busy1 !== 1'b1) begin
                errors++; $display("FAIL rand_accept: got ok=%0b busy=%0b expected 1 1 (instr %0h)", o_ok, o_busy1, b);
            end
            if (op == 4'hA) begin
                checks++;
                if (o_endk !== 2 || o_nwr !== 0) begin
                    errors++; $display("FAIL rand_ldi_imm: got k=%0d n=%0d expected 2 0 (instr %0h)", o_endk, o_nwr, b);
                end
                gap = $urandom_range(0, 3);
                bad = 0;
                for (int i = 0; i < gap; i++) begin
                    if (instr_ready !== 1'b1 || busy !== 1'b1) bad++;
                    @(negedge clk);
                end
                checks++;
                if (bad !== 0) begin errors++; $display("FAIL rand_ldi_gap: got %0d bad expected 0", bad); end
                ib = 8'($urandom_range(0, 255));
                send_byte(ib);
                if (o_ok) observe();
                else o_endk = -1;
                m_count++;
                checks++;
                if (o_nwr !== 1 || o_wrk !== 1 || o_endk !== 2) begin
                    errors++; $display("FAIL rand_ldi_timing: got n=%0d k=%0d end=%0d expected 1 1 2", o_nwr, o_wrk, o_endk);
                end
                checks++;
                if ({o_addr, o_src, o_imm} !== {b[3:2], 2'd1, ib}) begin
                    errors++; $display("FAIL rand_ldi_write: got %0h expected %0h", {o_addr, o_src, o_imm}, {b[3:2], 2'd1, ib});
                end
            end else begin
                wrs = is_alu_op(op) || (op == 4'hB);
                checks++;
                if (o_nwr !== (wrs ? 1 : 0)) begin
                    errors++; $display("FAIL rand_wr_count: got %0d expected %0d (instr %0h)", o_nwr, wrs ? 1 : 0, b);
                end
                if (wrs) begin
                    checks++;
                    if (o_wrk !== exp_wr_k(op)) begin
                        errors++; $display("FAIL rand_wr_cycle: got %0d expected %0d (instr %0h)", o_wrk, exp_wr_k(op), b);
                    end
                    checks++;
                    if ({o_addr, o_rda, o_rdb, o_src} !== {b[3:2], b[3:2], b[1:0], exp_src(op)}) begin
                        errors++; $display("FAIL rand_wr_fields: got %0h expected %0h (instr %0h)",
                            {o_addr, o_rda, o_rdb, o_src}, {b[3:2], b[3:2], b[1:0], exp_src(op)}, b);
                    end
                    if (is_alu_op(op)) begin
                        checks++;
                        if (o_alu !== op) begin errors++; $display("FAIL rand_alu_sel: got %0h expected %0h", o_alu, op); end
                    end
                end
                checks++;
                if (o_endk !== exp_end_k(op)) begin
                    errors++; $display("FAIL rand_end_cycle: got %0d expected %0d (instr %0h)", o_endk, exp_end_k(op), b);
                end
                if (op >= 4'hC && op <= 4'hE) m_illegal = 1'b1;
                m_count++;
                if (op == 4'hF) begin
                    checks++;
                    if (halted !== 1'b1) begin errors++; $display("FAIL rand_halt: got %0b expected 1", halted); end
                    wake($urandom_range(1, 4), bad, woke);
                    checks++;
                    if (bad !== 0 || woke !== 1'b1) begin
                        errors++; $display("FAIL rand_wake: got bad=%0d woke=%0b expected 0 1", bad, woke);
                    end
                end
            end
            checks++;
            if (illegal !== m_illegal) begin errors++; $display("FAIL rand_illegal: got %0b expected %0b", illegal, m_illegal); end
            checks++;
            if (instr_count !== exp_count()) begin
                errors++; $display("FAIL rand_count: got %0d expected %0d", instr_count, exp_count());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_ldi();
        test_illegal();
        test_halt();
        test_count();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
